// File: rtl/sd_init_sequencer_pkg.sv
// Shared constants and types for the SPI-mode SD card power-up sequencer.
// SD_INIT_CMD16_EN adds the CMD16 (block length 512) step for standard-capacity cards.
package sd_pkg;

    localparam logic [5:0] CMD0_IDX   = 6'd0;
    localparam logic [5:0] CMD8_IDX   = 6'd8;
    localparam logic [5:0] CMD16_IDX  = 6'd16;
    localparam logic [5:0] CMD55_IDX  = 6'd55;
    localparam logic [5:0] ACMD41_IDX = 6'd41;
    localparam logic [5:0] CMD58_IDX  = 6'd58;

    localparam logic [6:0] CRC_CMD0 = 7'h4A;
    localparam logic [6:0] CRC_CMD8 = 7'h43;
    localparam logic [6:0] CRC_NONE = 7'h7F;

    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_HCS    = 32'h4000_0000;
    localparam logic [31:0] ARG_BLKLEN = 32'd512;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_CMD0   = 3'd1,
        ERR_CMD8   = 3'd2,
        ERR_ACMD41 = 3'd3,
        ERR_CMD58  = 3'd4,
        ERR_CMD16  = 3'd5
    } err_code_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DUMMY,
        S_WDUMMY,
        S_CMD0,
        S_CMD8,
        S_CMD55,
        S_ACMD41,
        S_CMD58,
`ifdef SD_INIT_CMD16_EN
        S_CMD16,
`endif
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card init FSM: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Optional SD_INIT_CMD16_EN issues CMD16 (512-byte blocks) for standard-capacity cards.
module sd_init_sequencer
    import sd_pkg::*;
#(
    parameter int DUMMY_BYTES          = 10,
    parameter int CMD0_RETRIES         = 8,
    parameter int ACMD41_RETRIES       = 1000,
    parameter int NRESP_BYTES          = 8,
    parameter int MEMORY_SIZE_IN_BYTES = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    init_start,
    output logic                                    busy,
    output logic                                    init_done,
    output logic                                    init_error,
    output logic [2:0]                              err_code,
    output logic                                    card_hc,
    output logic                                    dummy_start,
    input  logic                                    dummy_done,
    output logic [5:0]                              cmd_cmd,
    output logic [31:0]                             cmd_arg,
    output logic [6:0]                              cmd_crc,
    output logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] cmd_nresponse,
    output logic                                    cmd_start,
    input  logic                                    cmd_done,
    input  logic [7:0]                              resp_r1,
    input  logic [31:0]                             resp_data,
    output logic [3:0]                              dbg_state
);

    localparam int NRESP_W   = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam int MAX_RETRY = (CMD0_RETRIES > ACMD41_RETRIES) ? CMD0_RETRIES : ACMD41_RETRIES;
    localparam int CNT_W     = $clog2(MAX_RETRY + 1);

    if (DUMMY_BYTES * 8 < 74) begin : g_chk_dummy
        $error("DUMMY_BYTES must give at least 74 SCK edges");
    end
    if (NRESP_BYTES < 5) begin : g_chk_nresp
        $error("NRESP_BYTES must be at least 5");
    end

    state_t           state_q, state_d, ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             hcs_q, hcs_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d, hc_q, hc_d;
    err_code_t        err_q, err_d;
    logic             dummy_start_q, dummy_start_d, cmd_start_q, cmd_start_d;
    logic [5:0]       cmd_q, cmd_d;
    logic [31:0]      arg_q, arg_d;
    logic [6:0]       crc_q, crc_d;
    logic             unused_resp;

    assign unused_resp = ^resp_data[29:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            cnt_q         <= '0;
            hcs_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            hc_q          <= 1'b0;
            err_q         <= ERR_NONE;
            dummy_start_q <= 1'b0;
            cmd_start_q   <= 1'b0;
            cmd_q         <= '0;
            arg_q         <= '0;
            crc_q         <= CRC_NONE;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            cnt_q         <= cnt_d;
            hcs_q         <= hcs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            hc_q          <= hc_d;
            err_q         <= err_d;
            dummy_start_q <= dummy_start_d;
            cmd_start_q   <= cmd_start_d;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            crc_q         <= crc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        hcs_d         = hcs_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        hc_d          = hc_q;
        err_d         = err_q;
        dummy_start_d = 1'b0;
        cmd_start_d   = 1'b0;
        cmd_d         = cmd_q;
        arg_d         = arg_q;
        crc_d         = crc_q;
        cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                    hcs_d   = 1'b0;
                    state_d = S_DUMMY;
                end
            end
            S_DUMMY: begin
                dummy_start_d = 1'b1;
                state_d       = S_WDUMMY;
            end
            S_WDUMMY: if (dummy_done) state_d = S_CMD0;
            S_CMD0: begin
                cmd_d = CMD0_IDX;  arg_d = '0;       crc_d = CRC_CMD0;
                ret_d = S_CMD0;    state_d = S_ISSUE;
            end
            S_CMD8: begin
                cmd_d = CMD8_IDX;  arg_d = ARG_CMD8; crc_d = CRC_CMD8;
                ret_d = S_CMD8;    state_d = S_ISSUE;
            end
            S_CMD55: begin
                cmd_d = CMD55_IDX; arg_d = '0;       crc_d = CRC_NONE;
                ret_d = S_CMD55;   state_d = S_ISSUE;
            end
            S_ACMD41: begin
                cmd_d = ACMD41_IDX; arg_d = hcs_q ? ARG_HCS : '0; crc_d = CRC_NONE;
                ret_d = S_ACMD41;   state_d = S_ISSUE;
            end
            S_CMD58: begin
                cmd_d = CMD58_IDX; arg_d = '0;       crc_d = CRC_NONE;
                ret_d = S_CMD58;   state_d = S_ISSUE;
            end
`ifdef SD_INIT_CMD16_EN
            S_CMD16: begin
                cmd_d = CMD16_IDX; arg_d = ARG_BLKLEN; crc_d = CRC_NONE;
                ret_d = S_CMD16;   state_d = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                cmd_start_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // The return state names which command the response belongs to.
                if (cmd_done) begin
                    case (ret_q)
                        S_CMD0: begin
                            if (resp_r1 == R1_IDLE) begin
                                cnt_d = '0; state_d = S_CMD8;
                            end else begin
                                cnt_d = cnt_inc;
                                if (cnt_inc >= CNT_W'(CMD0_RETRIES)) begin
                                    err_d = ERR_CMD0; state_d = S_ERR;
                                end else begin
                                    state_d = S_CMD0;
                                end
                            end
                        end
                        S_CMD8: begin
                            if (resp_r1 == (R1_IDLE | R1_ILLEGAL)) begin
                                hcs_d = 1'b0; cnt_d = '0; state_d = S_CMD55;
                            end else if (resp_r1 == R1_IDLE && resp_data[11:0] == ARG_CMD8[11:0]) begin
                                hcs_d = 1'b1; cnt_d = '0; state_d = S_CMD55;
                            end else begin
                                err_d = ERR_CMD8; state_d = S_ERR;
                            end
                        end
                        S_CMD55: begin
                            if (!resp_r1[7]) state_d = S_ACMD41;
                            else begin err_d = ERR_ACMD41; state_d = S_ERR; end
                        end
                        S_ACMD41: begin
                            if (resp_r1 == 8'h00) begin
                                cnt_d = '0; state_d = S_CMD58;
                            end else if (resp_r1 == R1_IDLE) begin
                                cnt_d = cnt_inc;
                                if (cnt_inc >= CNT_W'(ACMD41_RETRIES)) begin
                                    err_d = ERR_ACMD41; state_d = S_ERR;
                                end else begin
                                    state_d = S_CMD55;
                                end
                            end else begin
                                err_d = ERR_ACMD41; state_d = S_ERR;
                            end
                        end
                        S_CMD58: begin
                            if (resp_r1 == 8'h00 && resp_data[31]) begin
                                hc_d = resp_data[30];
`ifdef SD_INIT_CMD16_EN
                                state_d = resp_data[30] ? S_DONE : S_CMD16;
`else
                                state_d = S_DONE;
`endif
                            end else begin
                                err_d = ERR_CMD58; state_d = S_ERR;
                            end
                        end
`ifdef SD_INIT_CMD16_EN
                        S_CMD16: begin
                            if (resp_r1 == 8'h00) state_d = S_DONE;
                            else begin err_d = ERR_CMD16; state_d = S_ERR; end
                        end
`endif
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE: begin
                done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign init_done     = done_q;
    assign init_error    = error_q;
    assign err_code      = err_q;
    assign card_hc       = hc_q;
    assign dummy_start   = dummy_start_q;
    assign cmd_start     = cmd_start_q;
    assign cmd_cmd       = cmd_q;
    assign cmd_arg       = arg_q;
    assign cmd_crc       = crc_q;
    assign cmd_nresponse = NRESP_W'(NRESP_BYTES - 1);
    assign dbg_state     = state_q;

endmodule
